// File: rtl/signed_mac_pkg.sv
// Shared constants and types for the signed product accumulator slice.
package signed_mac_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int COUNT_MIN  = 1;
  localparam int COUNT_MAX  = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/signed_sat_add.sv
// Combinational ACC_W-wide signed adder with overflow detect.
// Optional macro SIGNED_ACC_SATURATE_EN clamps the sum on overflow;
// otherwise the sum wraps two's complement.
module signed_sat_add #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic signed [ACC_W:0] wide;

  assign wide = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
  // The two top bits of the one-bit-wider sum disagree exactly on signed overflow.
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef SIGNED_ACC_SATURATE_EN
  // Clamp toward the rail indicated by the true sign (the extra top bit).
  function automatic logic [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] w);
    logic [ACC_W-1:0] r;
    if (w[ACC_W] ^ w[ACC_W-1]) begin
      if (w[ACC_W]) r = {1'b1, {(ACC_W-1){1'b0}}};
      else          r = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      r = w[ACC_W-1:0];
    end
    return r;
  endfunction

  assign sum = sat_clamp(wide);
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/signed_product_accumulator.sv
// Signed product accumulator: sums frames of COUNT signed products into an
// ACC_W-bit result delivered over a valid/ready port with a sticky overflow
// flag. Saturation is selected with the SIGNED_ACC_SATURATE_EN macro.
module signed_product_accumulator
  import signed_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  state_t state_q, state_d;

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  p_ext_p0;
  logic [ACC_W-1:0]         sum_p0;
  logic                     step_ovf_p0;

  logic signed [ACC_W-1:0]  acc_p1;
  logic                     ovf_p1;
  logic [CNT_W-1:0]         cnt_p1;

  logic accept;
  logic take;

  // Stage p0: sign-extend the incoming product and form the next sum.
  assign prod_p0  = in_p;
  assign p_ext_p0 = ACC_W'(prod_p0);

  signed_sat_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc_p1),
    .b   (p_ext_p0),
    .sum (sum_p0),
    .ovf (step_ovf_p0)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; handshakes depend on state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (cnt_p1 == CNT_LAST)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        take      = out_ready;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage p1: accumulator, beat counter and sticky overflow; cleared on take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      cnt_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (take) begin
      acc_p1 <= '0;
      cnt_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (accept) begin
      acc_p1 <= $signed(sum_p0);
      cnt_p1 <= (cnt_p1 == CNT_LAST) ? '0 : cnt_p1 + 1'b1;
      ovf_p1 <= ovf_p1 | step_ovf_p0;
    end
  end

  assign out_sum = acc_p1;
  assign out_ovf = ovf_p1;

endmodule

// File: doc/signed_product_accumulator.md
# signed_product_accumulator

Downstream stage of the 4-bit signed multiplier. It consumes a stream of signed 8-bit products, sums a fixed-size frame of COUNT products into a wider signed accumulator, and presents one result per frame on a valid/ready output port. Every frame also reports an overflow flag. Saturating arithmetic is a compile-time option.

## Interface
- PROD_W, 8: product width; the input is signed two's complement.
- ACC_W, 12: accumulator and result width. Must satisfy ACC_W >= PROD_W.
- COUNT, 4: products per frame. Legal range is 1..16.
- clk  input  1  sole clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a product is presented on in_p.
- in_ready  output  1  the block can accept a product.
- in_p  input  PROD_W  signed product from the multiplier output P.
- out_valid  output  1  out_sum and out_ovf hold a completed frame.
- out_ready  input  1  the consumer accepts the result.
- out_sum  output  ACC_W  signed frame sum.
- out_ovf  output  1  at least one signed overflow occurred in the frame.

## Operation
- A beat is accepted on a rising edge where in_valid && in_ready. A result is taken on a rising edge where out_valid && out_ready.
- FSM states: ACCUM and DONE.
  - ACCUM: in_ready=1 and out_valid=0.
    - Each accepted beat does acc <= acc + sext(in_p) and cnt <= cnt+1.
    - On the beat where cnt==COUNT-1, the state moves to DONE.
    - Idle cycles (in_valid=0) leave acc and cnt unchanged.
  - DONE: in_ready=0 and out_valid=1. out_sum=acc and out_ovf=ovf are held stable until the result is taken.
  - On a result take, the state returns to ACCUM with acc=0, cnt=0, ovf=0.
- Arithmetic:
  - in_p is sign-extended to ACC_W, and the sum is computed at ACC_W+1 bits.
  - A step overflows when the two top bits of the ACC_W+1 sum differ.
  - ovf is sticky within a frame.
  - Without saturation the result wraps modulo 2^ACC_W.
- out_sum and out_ovf are registered, with no combinational path from in_p.
- in_ready depends only on the state. It has no combinational path from out_ready, so a frame restart costs one cycle.
- COUNT==1: every accepted beat moves the state to DONE.

## Timing
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- Latency: out_valid rises on the rising edge that accepts the COUNT-th beat. The result is visible in the cycle after the last beat.
- Throughput: at most COUNT products per COUNT+1 cycles when out_ready is held at 1. There is one DONE cycle per frame.
- Backpressure: with out_ready=0, DONE holds indefinitely and in_valid is ignored. The upstream stage must hold its beat.
- When out_ready is already 1 on entering DONE, the result is taken on the next edge and ACCUM resumes on the edge after that.
- Reset mid-frame aborts the partial frame immediately (asynchronous). No result is emitted for it, and the next frame starts from cnt=0.
- Reset while in DONE discards the pending result.

## Configuration
- SIGNED_ACC_SATURATE_EN defined:
  - A step that overflows clamps acc to +(2^(ACC_W-1)-1) on positive overflow or -(2^(ACC_W-1)) on negative overflow.
  - Later steps continue from the clamped value.
  - ovf is set.
- SIGNED_ACC_SATURATE_EN undefined: acc wraps two's complement. ovf is still set on any step overflow.
- The macro does not change the handshake or the timing.

## Structure
- Shared package signed_mac_pkg holds:
  - default width constants PROD_W_DEF=8 and ACC_W_DEF=12;
  - the state enum (ACCUM, DONE);
  - the COUNT range limits.
- Sub-module signed_sat_add (combinational, ACC_W wide) returns the sum and the overflow bit. It contains the saturation logic under SIGNED_ACC_SATURATE_EN.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- Basic frame (defaults): beats 1, -56, 64, 7 with out_ready=1 -> out_valid for 1 cycle, out_sum=16 (0x010), out_ovf=0.
- Backpressure: the same frame with out_ready=0 for 5 cycles -> out_valid held and out_sum stable at 16, in_ready=0 throughout, no beat accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- Overflow with ACC_W=8 and COUNT=4: four beats of 127 -> without the macro, out_sum=0xFC (-4) and out_ovf=1; with SIGNED_ACC_SATURATE_EN, out_sum=0x7F and out_ovf=1.
- Negative saturation with ACC_W=8 and the macro defined: beats -128, -128, 100, 0 -> out_sum=0xE4 (-28) and out_ovf=1. Clamping to -128 happens at the second beat.
- Gapped input: in_valid toggled 1,0,0,1,0,1,1 with products 5, 5, 5, 5 -> exactly one result, out_sum=20.
- Reset mid-frame: rst pulsed after 2 beats, then 4 beats of 3 -> all outputs at reset values during rst, one result out_sum=12, and no result from the aborted frame.
